// File: rtl/draw_card_grid.sv
// Memory-game card grid overlay: per-card state/face store, a fixed 3-cycle
// render pipeline that fetches face pixels from a registered ROM, and click hit-test.
module draw_card_grid #(
    parameter int          COLS        = 4,
    parameter int          ROWS        = 4,
    parameter int          CARD_W      = 128,
    parameter int          CARD_H      = 128,
    parameter int          GAP         = 16,
    parameter int          X0          = 120,
    parameter int          Y0          = 20,
    parameter int          BORDER      = 2,
    parameter int          SCALE       = 1,
    parameter int          IMG_BITS    = 6,
    parameter int          FACE_W      = 3,
    parameter logic [11:0] HIDDEN_RGB  = 12'h248,
    parameter logic [11:0] MATCHED_RGB = 12'h2A2,
    parameter logic [11:0] BORDER_RGB  = 12'hFFF
) (
    input  logic                            pclk,
    input  logic                            rst,
    input  logic [10:0]                     hcount_in,
    input  logic [10:0]                     vcount_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            hblnk_in,
    input  logic                            vblnk_in,
    input  logic [11:0]                     rgb_in,
    output logic [10:0]                     hcount_out,
    output logic [10:0]                     vcount_out,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            hblnk_out,
    output logic                            vblnk_out,
    output logic [11:0]                     rgb_out,
    output logic [FACE_W+2*IMG_BITS-1:0]    face_addr,
    input  logic [11:0]                     face_rgb,
    input  logic                            wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]    wr_idx,
    input  logic [1:0]                      wr_state,
    input  logic [FACE_W-1:0]               wr_face,
    input  logic [11:0]                     mouse_xpos,
    input  logic [11:0]                     mouse_ypos,
    input  logic                            mouse_left,
    output logic                            click_valid,
    output logic [$clog2(ROWS*COLS)-1:0]    click_idx
);
    localparam int N       = ROWS * COLS;
    localparam int IDX_W   = $clog2(N);
    localparam int FA_W    = FACE_W + 2 * IMG_BITS;
    localparam int PITCH_X = CARD_W + GAP;
    localparam int PITCH_Y = CARD_H + GAP;

    localparam logic [1:0] ST_HIDDEN   = 2'd0;
    localparam logic [1:0] ST_REVEALED = 2'd1;
    localparam logic [1:0] ST_MATCHED  = 2'd2;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    // Returns {on_card, idx}; one compare pair per column/row, no division.
    function automatic logic [IDX_W:0] card_at(input logic [11:0] x, input logic [11:0] y);
        logic col_hit;
        logic row_hit;
        int   col;
        int   row;
        col_hit = 1'b0;
        row_hit = 1'b0;
        col     = 0;
        row     = 0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(x) >= X0 + c * PITCH_X && int'(x) < X0 + c * PITCH_X + CARD_W) begin
                col_hit = 1'b1;
                col     = c;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (int'(y) >= Y0 + r * PITCH_Y && int'(y) < Y0 + r * PITCH_Y + CARD_H) begin
                row_hit = 1'b1;
                row     = r;
            end
        end
        return {col_hit & row_hit, IDX_W'(row * COLS + col)};
    endfunction

    // Offset from the nearest card start at or before x; meaningful only on a card.
    function automatic logic [11:0] x_offset(input logic [11:0] x);
        logic [11:0] off;
        off = '0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(x) >= X0 + c * PITCH_X) off = 12'(int'(x) - (X0 + c * PITCH_X));
        end
        return off;
    endfunction

    function automatic logic [11:0] y_offset(input logic [11:0] y);
        logic [11:0] off;
        off = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(y) >= Y0 + r * PITCH_Y) off = 12'(int'(y) - (Y0 + r * PITCH_Y));
        end
        return off;
    endfunction

    logic [1:0]        card_state_q [N];
    logic [1:0]        card_state_d [N];
    logic [FACE_W-1:0] card_face_q  [N];
    logic [FACE_W-1:0] card_face_d  [N];

    logic [IDX_W:0]    px_card;
    logic [IDX_W:0]    ms_card;
    logic              px_hit;
    logic [IDX_W-1:0]  px_idx;
    logic [11:0]       px_x_off;
    logic [11:0]       px_y_off;
    logic              ms_hit;
    logic [IDX_W-1:0]  ms_idx;

    timing_t           tim_s1_q, tim_s1_d, tim_s2_q, tim_s2_d, tim_s3_q, tim_s3_d;
    logic [11:0]       rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d, rgb_s3_q, rgb_s3_d;
    logic              card_s1_q, card_s1_d, card_s2_q, card_s2_d;
    logic              border_s1_q, border_s1_d, border_s2_q, border_s2_d;
    logic [1:0]        state_s1_q, state_s1_d, state_s2_q, state_s2_d;
    logic [FA_W-1:0]   face_addr_q, face_addr_d;

    logic              prev_left_q, prev_left_d;
    logic              click_valid_q, click_valid_d;
    logic [IDX_W-1:0]  click_idx_q, click_idx_d;

    always_comb begin
        px_card  = card_at({1'b0, hcount_in}, {1'b0, vcount_in});
        px_hit   = px_card[IDX_W];
        px_idx   = px_card[IDX_W-1:0];
        px_x_off = x_offset({1'b0, hcount_in});
        px_y_off = y_offset({1'b0, vcount_in});
        ms_card  = card_at(mouse_xpos, mouse_ypos);
        ms_hit   = ms_card[IDX_W];
        ms_idx   = ms_card[IDX_W-1:0];
    end

    // State code 3 is folded to hidden on write so readers only see 0..2.
    always_comb begin
        card_state_d = card_state_q;
        card_face_d  = card_face_q;
        if (wr_en && 32'(wr_idx) < N) begin
            card_state_d[wr_idx] = (wr_state == 2'd3) ? ST_HIDDEN : wr_state;
            card_face_d[wr_idx]  = wr_face;
        end
    end

    always_comb begin
        tim_s1_d    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
        rgb_s1_d    = rgb_in;
        card_s1_d   = px_hit;
        border_s1_d = (int'(px_x_off) < BORDER) || (int'(px_x_off) >= CARD_W - BORDER) ||
                      (int'(px_y_off) < BORDER) || (int'(px_y_off) >= CARD_H - BORDER);
        state_s1_d  = card_state_q[px_idx];
        face_addr_d = {card_face_q[px_idx], IMG_BITS'(px_y_off >> SCALE), IMG_BITS'(px_x_off >> SCALE)};

        tim_s2_d    = tim_s1_q;
        rgb_s2_d    = rgb_s1_q;
        card_s2_d   = card_s1_q;
        border_s2_d = border_s1_q;
        state_s2_d  = state_s1_q;

        // face_rgb belongs to the pixel now in S2: the ROM registered face_addr_q one edge ago.
        tim_s3_d = tim_s2_q;
        if (tim_s2_q.hblnk || tim_s2_q.vblnk) begin
            rgb_s3_d = 12'h000;
        end else if (!card_s2_q) begin
            rgb_s3_d = rgb_s2_q;
        end else if (border_s2_q) begin
            rgb_s3_d = BORDER_RGB;
        end else begin
            case (state_s2_q)
                ST_REVEALED: rgb_s3_d = face_rgb;
                ST_MATCHED:  rgb_s3_d = MATCHED_RGB;
                default:     rgb_s3_d = HIDDEN_RGB;
            endcase
        end
    end

    // click_valid is a one-cycle strobe with no backpressure; click_idx holds until the next click.
    always_comb begin
        prev_left_d   = mouse_left;
        click_valid_d = 1'b0;
        click_idx_d   = click_idx_q;
        if (mouse_left && !prev_left_q && ms_hit && card_state_q[ms_idx] == ST_HIDDEN) begin
            click_valid_d = 1'b1;
            click_idx_d   = ms_idx;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                card_state_q[i] <= ST_HIDDEN;
                card_face_q[i]  <= '0;
            end
            tim_s1_q      <= '0;
            tim_s2_q      <= '0;
            tim_s3_q      <= '0;
            rgb_s1_q      <= '0;
            rgb_s2_q      <= '0;
            rgb_s3_q      <= '0;
            card_s1_q     <= 1'b0;
            card_s2_q     <= 1'b0;
            border_s1_q   <= 1'b0;
            border_s2_q   <= 1'b0;
            state_s1_q    <= ST_HIDDEN;
            state_s2_q    <= ST_HIDDEN;
            face_addr_q   <= '0;
            prev_left_q   <= 1'b0;
            click_valid_q <= 1'b0;
            click_idx_q   <= '0;
        end else begin
            card_state_q  <= card_state_d;
            card_face_q   <= card_face_d;
            tim_s1_q      <= tim_s1_d;
            tim_s2_q      <= tim_s2_d;
            tim_s3_q      <= tim_s3_d;
            rgb_s1_q      <= rgb_s1_d;
            rgb_s2_q      <= rgb_s2_d;
            rgb_s3_q      <= rgb_s3_d;
            card_s1_q     <= card_s1_d;
            card_s2_q     <= card_s2_d;
            border_s1_q   <= border_s1_d;
            border_s2_q   <= border_s2_d;
            state_s1_q    <= state_s1_d;
            state_s2_q    <= state_s2_d;
            face_addr_q   <= face_addr_d;
            prev_left_q   <= prev_left_d;
            click_valid_q <= click_valid_d;
            click_idx_q   <= click_idx_d;
        end
    end

    assign hcount_out  = tim_s3_q.hcount;
    assign vcount_out  = tim_s3_q.vcount;
    assign hsync_out   = tim_s3_q.hsync;
    assign vsync_out   = tim_s3_q.vsync;
    assign hblnk_out   = tim_s3_q.hblnk;
    assign vblnk_out   = tim_s3_q.vblnk;
    assign rgb_out     = rgb_s3_q;
    assign face_addr   = face_addr_q;
    assign click_valid = click_valid_q;
    assign click_idx   = click_idx_q;

endmodule

// File: tb/tb_draw_card_grid.sv
// Bench for draw_card_grid: pixel vectors and click expectations are queued when
// driven and compared when the DUT produces them (3 cycles for pixels, 1 for clicks).
module tb_draw_card_grid;
    localparam int IDX_W = 4;
    localparam int FA_W  = 15;
    localparam int EXP_W = 38;
    localparam int NVEC  = 18;

    logic              pclk;
    logic              rst;
    logic [10:0]       hcount_in, vcount_in;
    logic              hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0]       rgb_in;
    logic [10:0]       hcount_out, vcount_out;
    logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]       rgb_out;
    logic [FA_W-1:0]   face_addr;
    logic [11:0]       face_rgb;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        wr_state;
    logic [2:0]        wr_face;
    logic [11:0]       mouse_xpos, mouse_ypos;
    logic              mouse_left;
    logic              click_valid;
    logic [IDX_W-1:0]  click_idx;

    draw_card_grid dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out),
        .face_addr(face_addr), .face_rgb(face_rgb),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_state(wr_state), .wr_face(wr_face),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
        .click_valid(click_valid), .click_idx(click_idx)
    );

    // Clock / reset block
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Registered face ROM model: one address returns a marker colour, the rest a fixed scramble.
    function automatic logic [11:0] rom_fn(input logic [FA_W-1:0] a);
        if (a == 15'd13578) return 12'hABC;
        return a[11:0] ^ 12'h3C3;
    endfunction

    always @(posedge pclk) face_rgb <= rom_fn(face_addr);

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        hb;
        logic        vb;
        logic [11:0] rgb_in;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t              vecs [NVEC];
    logic [EXP_W-1:0]  exp_q[$];
    int                exp_cyc_q[$];
    logic [IDX_W-1:0]  click_q[$];
    int                click_cyc_q[$];
    int                cyc;
    int                checks;
    int                failures;
    int                spur_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, want);
        end
    endtask

    // Scoreboard: runs once per cycle on the falling edge.
    task automatic sb_check();
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp_v;
        logic [IDX_W-1:0] exp_idx;
        int               due;
        if (rst) begin
            got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] + 3 <= cyc) begin
                exp_v = exp_q.pop_front();
                due   = exp_cyc_q.pop_front() + 3;
                checks++;
                if (due != cyc) begin
                    failures++;
                    $display("FAIL pixel_timing cycle=%0d due=%0d", cyc, due);
                end else if (got !== exp_v) begin
                    failures++;
                    $display("FAIL pixel got hc=%0d vc=%0d sync/blnk=%b rgb=%h exp hc=%0d vc=%0d sync/blnk=%b rgb=%h",
                             got[37:27], got[26:16], got[15:12], got[11:0],
                             exp_v[37:27], exp_v[26:16], exp_v[15:12], exp_v[11:0]);
                end
            end
            if (click_cyc_q.size() > 0 && click_cyc_q[0] + 1 <= cyc) begin
                exp_idx = click_q.pop_front();
                due     = click_cyc_q.pop_front() + 1;
                checks++;
                if (due != cyc || click_valid !== 1'b1 || click_idx !== exp_idx) begin
                    failures++;
                    $display("FAIL click got valid=%b idx=%0d exp valid=1 idx=%0d", click_valid, click_idx, exp_idx);
                end
            end else if (click_valid === 1'b1) begin
                spur_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        sb_check();
        @(posedge pclk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        hcount_in = '0;
        vcount_in = '0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = '0;
        repeat (n) tick();
    endtask

    task automatic drive_pix(input logic [10:0] x, input logic [10:0] y, input logic hb, input logic vb,
                             input logic [11:0] rgb, input logic [11:0] exp_rgb);
        logic hs, vs;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        hcount_in = x;
        vcount_in = y;
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        exp_q.push_back({x, y, hs, vs, hb, vb, exp_rgb});
        exp_cyc_q.push_back(cyc);
        tick();
    endtask

    task automatic write_card(input logic [IDX_W-1:0] idx, input logic [1:0] st, input logic [2:0] face);
        wr_en    = 1'b1;
        wr_idx   = idx;
        wr_state = st;
        wr_face  = face;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic click_seq(input string name, input logic [11:0] x, input logic [11:0] y,
                             input logic expect_pulse, input logic [IDX_W-1:0] idx);
        spur_cnt   = 0;
        mouse_xpos = x;
        mouse_ypos = y;
        mouse_left = 1'b0;
        repeat (2) tick();
        mouse_left = 1'b1;
        if (expect_pulse) begin
            click_q.push_back(idx);
            click_cyc_q.push_back(cyc);
        end
        repeat (10) tick();
        mouse_left = 1'b0;
        repeat (3) tick();
        check({name, "_extra_pulses"}, 32'(spur_cnt), 32'd0);
        if (expect_pulse) check({name, "_idx_held"}, 32'(click_idx), 32'(idx));
    endtask

    initial begin
        vecs[0]  = '{11'd130, 11'd30,  1'b0, 1'b0, 12'h123, 12'h248};
        vecs[1]  = '{11'd284, 11'd204, 1'b0, 1'b0, 12'h123, 12'hABC};
        vecs[2]  = '{11'd300, 11'd230, 1'b0, 1'b0, 12'h456, 12'hB91};
        vecs[3]  = '{11'd120, 11'd30,  1'b0, 1'b0, 12'h111, 12'hFFF};
        vecs[4]  = '{11'd250, 11'd30,  1'b0, 1'b0, 12'h5A5, 12'h5A5};
        vecs[5]  = '{11'd130, 11'd30,  1'b1, 1'b0, 12'h321, 12'h000};
        vecs[6]  = '{11'd130, 11'd30,  1'b0, 1'b1, 12'h321, 12'h000};
        vecs[7]  = '{11'd247, 11'd147, 1'b0, 1'b0, 12'h222, 12'hFFF};
        vecs[8]  = '{11'd245, 11'd30,  1'b0, 1'b0, 12'h222, 12'h248};
        vecs[9]  = '{11'd246, 11'd30,  1'b0, 1'b0, 12'h222, 12'hFFF};
        vecs[10] = '{11'd100, 11'd30,  1'b0, 1'b0, 12'h777, 12'h777};
        vecs[11] = '{11'd130, 11'd10,  1'b0, 1'b0, 12'h888, 12'h888};
        vecs[12] = '{11'd600, 11'd500, 1'b0, 1'b0, 12'h999, 12'h248};
        vecs[13] = '{11'd264, 11'd164, 1'b0, 1'b0, 12'h0F0, 12'hFFF};
        vecs[14] = '{11'd130, 11'd150, 1'b0, 1'b0, 12'h0F0, 12'h0F0};
        vecs[15] = '{11'd690, 11'd30,  1'b0, 1'b0, 12'h135, 12'h135};
        vecs[16] = '{11'd266, 11'd166, 1'b0, 1'b0, 12'h246, 12'h382};
        vecs[17] = '{11'd551, 11'd451, 1'b0, 1'b0, 12'h0AA, 12'h0AA};

        cyc = 0; checks = 0; failures = 0; spur_cnt = 0;
        rst = 1'b0;
        hcount_in = 11'd130; vcount_in = 11'd30;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
        rgb_in = 12'h123;
        wr_en = 1'b0; wr_idx = '0; wr_state = '0; wr_face = '0;
        mouse_xpos = 12'd130; mouse_ypos = 12'd30; mouse_left = 1'b0;

        repeat (4) tick();
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_hcount_out", 32'(hcount_out), 32'd0);
        check("rst_sync_blnk", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("rst_face_addr", 32'(face_addr), 32'd0);
        check("rst_click_valid", 32'(click_valid), 32'd0);

        rst = 1'b1;
        drive_pix(11'd130, 11'd30, 1'b0, 1'b0, 12'h123, 12'h248);
        drive_pix(11'd131, 11'd31, 1'b0, 1'b0, 12'h124, 12'h248);
        idle(4);

        // Reveal card 5 with face 3, then check the ROM address the S1 stage issues.
        write_card(4'd5, 2'd1, 3'd3);
        drive_pix(11'd284, 11'd204, 1'b0, 1'b0, 12'h123, 12'hABC);
        check("face_addr_card5", 32'(face_addr), 32'd13578);
        idle(4);

        for (int i = 0; i < NVEC; i++) begin
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].hb, vecs[i].vb, vecs[i].rgb_in, vecs[i].exp_rgb);
        end
        idle(5);

        // State code 3 reads back as hidden; then restore card 5 revealed.
        write_card(4'd5, 2'd3, 3'd3);
        drive_pix(11'd284, 11'd204, 1'b0, 1'b0, 12'h123, 12'h248);
        write_card(4'd5, 2'd1, 3'd3);
        drive_pix(11'd284, 11'd204, 1'b0, 1'b0, 12'h123, 12'hABC);
        idle(4);

        click_seq("click_card0", 12'd130, 12'd30, 1'b1, 4'd0);
        click_seq("click_card1_border", 12'd264, 12'd20, 1'b1, 4'd1);
        click_seq("click_card15", 12'd600, 12'd500, 1'b1, 4'd15);
        click_seq("click_gap", 12'd250, 12'd30, 1'b0, 4'd0);
        click_seq("click_revealed", 12'd284, 12'd204, 1'b0, 4'd0);
        click_seq("click_outside", 12'd100, 12'd10, 1'b0, 4'd0);

        // Write card 0 matched on the same edge the click is sampled: click sees the old state.
        spur_cnt   = 0;
        mouse_xpos = 12'd130;
        mouse_ypos = 12'd30;
        mouse_left = 1'b0;
        repeat (2) tick();
        wr_en = 1'b1; wr_idx = 4'd0; wr_state = 2'd2; wr_face = 3'd0;
        mouse_left = 1'b1;
        click_q.push_back(4'd0);
        click_cyc_q.push_back(cyc);
        tick();
        wr_en = 1'b0;
        repeat (5) tick();
        mouse_left = 1'b0;
        repeat (2) tick();
        check("click_write_same_cycle_extra", 32'(spur_cnt), 32'd0);
        drive_pix(11'd130, 11'd30, 1'b0, 1'b0, 12'h123, 12'h2A2);
        drive_pix(11'd200, 11'd100, 1'b0, 1'b0, 12'h123, 12'h2A2);
        idle(4);
        click_seq("click_matched", 12'd130, 12'd30, 1'b0, 4'd0);

        // Reset mid-line while a hidden card is on screen and a click pulse is live.
        hcount_in = 11'd420; vcount_in = 11'd30; hblnk_in = 1'b0; vblnk_in = 1'b0;
        mouse_xpos = 12'd420; mouse_ypos = 12'd30; mouse_left = 1'b0;
        repeat (4) tick();
        mouse_left = 1'b1;
        tick();
        check("pre_rst_rgb", 32'(rgb_out), 32'h248);
        check("pre_rst_click_valid", 32'(click_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rgb", 32'(rgb_out), 32'd0);
        check("mid_rst_click_valid", 32'(click_valid), 32'd0);
        check("mid_rst_hcount", 32'(hcount_out), 32'd0);
        mouse_left = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        drive_pix(11'd284, 11'd204, 1'b0, 1'b0, 12'h321, 12'h248);
        check("fill_rgb_zero", 32'(rgb_out), 32'd0);
        drive_pix(11'd130, 11'd30, 1'b0, 1'b0, 12'h321, 12'h248);
        idle(5);

        check("pixel_queue_drained", 32'(exp_q.size()), 32'd0);
        check("click_queue_drained", 32'(click_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
